// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types for the obstacle track sequencer.
// Word layout, obstacle kinds, lane count, FSM states and the
// OBSTACLE_SEQ_SKIP_EMPTY_EN build switch (skip OBS_NONE slots).
package obstacle_pkg;

    localparam int OBS_LANES = 3;
    localparam int OBS_W     = 16;

`ifdef OBSTACLE_SEQ_SKIP_EMPTY_EN
    localparam bit OBS_SKIP_EMPTY = 1'b1;
`else
    localparam bit OBS_SKIP_EMPTY = 1'b0;
`endif

    typedef enum logic [2:0] {
        OBS_NONE    = 3'd0,
        OBS_BARRIER = 3'd1,
        OBS_TRAIN   = 3'd2,
        OBS_RAMP    = 3'd3
    } obs_kind_e;

    typedef struct packed {
        obs_kind_e   kind;
        logic [4:0]  height;
        logic [7:0]  rsvd;
    } obs_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADVANCE,
        ST_STREAM,
        ST_DONE
    } seq_state_e;

    // A slot is presented unless empty-skipping is built in and it is empty.
    function automatic logic obs_present(input obs_word_t w);
        return !OBS_SKIP_EMPTY || (w.kind != OBS_NONE);
    endfunction

endpackage

// File: rtl/obstacle_row_fifo.sv
// obstacle_row_fifo: ring buffer of obstacle rows with push/pop and two
// random read ports indexed relative to the head (0 = front row).
// Ports: clk, rst, push/push_data, pop, rd_idx_a/rd_data_a,
// rd_idx_b/rd_data_b, count (rows held). Caller never overflows/underflows.
module obstacle_row_fifo
    import obstacle_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int W    = OBS_W * OBS_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    input  logic [$clog2(ROWS)-1:0] rd_idx_a,
    output logic [W-1:0]            rd_data_a,
    input  logic [$clog2(ROWS)-1:0] rd_idx_b,
    output logic [W-1:0]            rd_data_b,
    output logic [$clog2(ROWS):0]   count
);

    localparam int AW = $clog2(ROWS);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [ROWS];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;

    // Pointers wrap for free since ROWS is a power of two.
    assign addr_a    = head + rd_idx_a;
    assign addr_b    = head + rd_idx_b;
    assign rd_data_a = mem[addr_a];
    assign rd_data_b = mem[addr_b];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer: per-frame scroll advance, front-row retire and
// obstacle word streaming. OBSTACLE_SEQ_SKIP_EMPTY_EN hides OBS_NONE slots.
// Ports: clk, rst, new_frame, scroll_step, pause, in_row/in_valid/in_ready,
// obs_word/lane/row_idx/first_row/valid/ready, row_progress, count,
// frame_done, underflow, overrun.
module obstacle_sequencer
    import obstacle_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int BLOCK_LENGTH = 64,
    parameter int LANES        = OBS_LANES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     new_frame,
    input  logic [7:0]               scroll_step,
    input  logic                     pause,
    input  logic [OBS_W*LANES-1:0]   in_row,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [15:0]              obs_word,
    output logic [1:0]               obs_lane,
    output logic [$clog2(ROWS)-1:0]  obs_row_idx,
    output logic                     obs_first_row,
    output logic                     obs_valid,
    input  logic                     obs_ready,
    output logic [15:0]              row_progress,
    output logic [$clog2(ROWS):0]    count,
    output logic                     frame_done,
    output logic                     underflow,
    output logic                     overrun
);

    localparam int          AW        = $clog2(ROWS);
    localparam int          CW        = AW + 1;
    localparam int          RW        = OBS_W * LANES;
    localparam logic [1:0]  LAST_LANE = 2'(LANES - 1);
    localparam logic [16:0] BL17      = 17'(BLOCK_LENGTH);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic [1:0]    lane_q, lane_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] rows_q, rows_d;
    logic [15:0]   prog_q, prog_d;
    logic [7:0]    step_q, step_d;
    logic          unf_q, unf_d;
    logic          ovr_q, ovr_d;

    logic          push;
    logic          pop;
    logic          roll;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] rows_next;
    logic [RW-1:0] cur_row;
    logic [RW-1:0] tgt_row;
    logic [AW-1:0] tgt_idx;
    logic [1:0]    tgt_lane;
    logic          tgt_is_new;
    obs_word_t     tgt_word;
    logic [16:0]   sum;
    logic [16:0]   excess;
    logic          last_slot;

    assign in_ready = (fifo_count < CW'(ROWS)) && !rst;
    assign push     = in_valid && in_ready;

    obstacle_row_fifo #(
        .ROWS (ROWS),
        .W    (RW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_row),
        .pop       (pop),
        .rd_idx_a  (row_q),
        .rd_data_a (cur_row),
        .rd_idx_b  (tgt_idx),
        .rd_data_b (tgt_row),
        .count     (fifo_count)
    );

    assign sum       = {1'b0, prog_q} + 17'(step_q);
    assign excess    = sum - BL17;
    assign roll      = (state_q == ST_ADVANCE) && !pause && (sum >= BL17);
    assign pop       = roll && (fifo_count != '0);
    assign rows_next = fifo_count + CW'(push) - CW'(pop);
    assign last_slot = ({1'b0, row_q} == rows_q - CW'(1))
                    && (lane_q == LAST_LANE);

    // Next slot to look at. During ADVANCE the head has not moved yet,
    // so the new front row sits one slot further in when popping.
    always_comb begin
        tgt_idx  = row_q;
        tgt_lane = lane_q + 2'd1;
        if (state_q == ST_ADVANCE) begin
            tgt_idx  = AW'(pop);
            tgt_lane = 2'd0;
        end else if (lane_q == LAST_LANE) begin
            tgt_idx  = row_q + AW'(1);
            tgt_lane = 2'd0;
        end
    end

    // A row pushed during ADVANCE is not in memory yet; look at it directly.
    assign tgt_is_new = (state_q == ST_ADVANCE) && push
                     && ({1'b0, tgt_idx} == fifo_count);
    assign tgt_word   = tgt_is_new ? obs_word_t'(in_row[{tgt_lane, 4'd0} +: 16])
                                   : obs_word_t'(tgt_row[{tgt_lane, 4'd0} +: 16]);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        rows_d  = rows_q;
        prog_d  = prog_q;
        step_d  = step_q;
        unf_d   = unf_q;
        ovr_d   = ovr_q | (new_frame && (state_q != ST_IDLE));
        unique case (state_q)
            ST_IDLE: begin
                if (new_frame) begin
                    state_d = ST_ADVANCE;
                    step_d  = scroll_step;
                end
            end
            ST_ADVANCE: begin
                if (roll) begin
                    // One retire per frame; leftover scroll saturates.
                    prog_d = (excess >= BL17) ? 16'(BLOCK_LENGTH - 1)
                                              : excess[15:0];
                    if (fifo_count == '0) unf_d = 1'b1;
                end else if (!pause) begin
                    prog_d = sum[15:0];
                end
                rows_d = rows_next;
                row_d  = '0;
                lane_d = 2'd0;
                if (rows_next == '0) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_STREAM;
                    valid_d = obs_present(tgt_word);
                end
            end
            ST_STREAM: begin
                // Move on after a handshake, or every cycle while skipping.
                if (!valid_q || obs_ready) begin
                    if (last_slot) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                    end else begin
                        row_d   = tgt_idx;
                        lane_d  = tgt_lane;
                        valid_d = obs_present(tgt_word);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            lane_q  <= 2'd0;
            valid_q <= 1'b0;
            rows_q  <= '0;
            prog_q  <= '0;
            step_q  <= '0;
            unf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            rows_q  <= rows_d;
            prog_q  <= prog_d;
            step_q  <= step_d;
            unf_q   <= unf_d;
            ovr_q   <= ovr_d;
        end
    end

    assign obs_valid     = valid_q;
    assign obs_word      = valid_q ? cur_row[{lane_q, 4'd0} +: 16] : 16'd0;
    assign obs_lane      = lane_q;
    assign obs_row_idx   = row_q;
    assign obs_first_row = valid_q && (row_q == '0);
    assign row_progress  = prog_q;
    assign count         = fifo_count;
    assign frame_done    = (state_q == ST_DONE);
    assign underflow     = unf_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_obstacle_sequencer.sv
// tb_obstacle_sequencer: random rows and frames against a queue model of
// the row buffer; expected words go to a scoreboard checked by a monitor.
module tb_obstacle_sequencer;

    localparam int ROWS  = 8;
    localparam int BL    = 64;
    localparam int LANES = 3;
`ifdef OBSTACLE_SEQ_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [15:0] w;
        int          l;
        int          r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_frame = 1'b0;
    logic [7:0]  scroll_step = 8'd0;
    logic        pause = 1'b0;
    logic [47:0] in_row = '0;
    logic        in_valid = 1'b0;
    logic        obs_ready = 1'b0;
    logic        in_ready;
    logic [15:0] obs_word;
    logic [1:0]  obs_lane;
    logic [2:0]  obs_row_idx;
    logic        obs_first_row;
    logic        obs_valid;
    logic [15:0] row_progress;
    logic [3:0]  count;
    logic        frame_done;
    logic        underflow;
    logic        overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_hs = 0;
    bit stall = 1'b0;

    logic [47:0] q[$];
    exp_t        exp_q[$];
    int          m_prog = 0;
    bit          m_unf = 1'b0;
    bit          m_ovr = 1'b0;

    bit          hold = 1'b0;
    logic [15:0] hold_w;
    logic [1:0]  hold_l;
    logic [2:0]  hold_r;

    obstacle_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .new_frame     (new_frame),
        .scroll_step   (scroll_step),
        .pause         (pause),
        .in_row        (in_row),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .obs_word      (obs_word),
        .obs_lane      (obs_lane),
        .obs_row_idx   (obs_row_idx),
        .obs_first_row (obs_first_row),
        .obs_valid     (obs_valid),
        .obs_ready     (obs_ready),
        .row_progress  (row_progress),
        .count         (count),
        .frame_done    (frame_done),
        .underflow     (underflow),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        obs_ready = !stall && ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, frame_done bookkeeping.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold)
                chk("stall_hold", {obs_valid, obs_word, obs_lane, obs_row_idx},
                    {1'b1, hold_w, hold_l, hold_r});
            if (obs_valid && obs_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got %0h want none", obs_word);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("obs_word", obs_word, e.w);
                    chk("obs_lane", obs_lane, e.l);
                    chk("obs_row_idx", obs_row_idx, e.r);
                    chk("obs_first_row", obs_first_row, e.r == 0);
                end
                last_hs = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold   = obs_valid && !obs_ready;
            hold_w = obs_word;
            hold_l = obs_lane;
            hold_r = obs_row_idx;
        end
    end

    function automatic logic [47:0] rand_row();
        logic [47:0] r;
        int k;
        for (int l = 0; l < LANES; l++) begin
            k = $urandom_range(0, 5);
            if (k > 3) k = 0;
            r[l*16 +: 16] = {3'(k), 5'($urandom_range(0, 31)),
                             8'($urandom_range(0, 255))};
        end
        return r;
    endfunction

    task automatic check_zero(input string name);
        chk(name, {in_ready, obs_valid, obs_word, obs_lane, obs_row_idx,
                   obs_first_row, row_progress, count, frame_done,
                   underflow, overrun}, 64'd0);
    endtask

    task automatic push_row(input logic [47:0] r);
        chk("push_in_ready", in_ready, q.size() < ROWS);
        in_valid = 1'b1;
        in_row   = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (q.size() < ROWS) q.push_back(r);
    endtask

    // Frame rules: scroll unless paused, retire at most one row, then
    // stream every buffered slot (non-empty ones only when skipping).
    task automatic model_frame(input int step, input bit adv,
                               input logic [47:0] nr, output int pre,
                               output int rows, output int words);
        int sum;
        logic [47:0] t;
        exp_t e;
        pre = q.size();
        if (!pause) begin
            sum = m_prog + step;
            if (sum >= BL) begin
                if (pre == 0) m_unf = 1'b1;
                else void'(q.pop_front());
                m_prog = (sum - BL >= BL) ? BL - 1 : sum - BL;
            end else begin
                m_prog = sum;
            end
        end
        if (adv && pre < ROWS) q.push_back(nr);
        rows  = q.size();
        words = 0;
        for (int r = 0; r < rows; r++) begin
            t = q[r];
            for (int l = 0; l < LANES; l++) begin
                e.w = t[l*16 +: 16];
                e.l = l;
                e.r = r;
                if (!SKIP || e.w[15:13] != 3'd0) begin
                    exp_q.push_back(e);
                    words++;
                end
            end
        end
    endtask

    task automatic do_frame(input int step, input bit adv, input bit ovr,
                            input bit stall_p);
        int pre, rows, words, start, nf;
        logic [47:0] nr;
        nr = rand_row();
        model_frame(step, adv, nr, pre, rows, words);
        if (ovr) m_ovr = 1'b1;
        start       = done_cnt;
        new_frame   = 1'b1;
        scroll_step = 8'(step);
        nf          = cyc;
        @(posedge clk);
        #1;
        new_frame = 1'b0;
        if (adv) begin
            chk("adv_in_ready", in_ready, pre < ROWS);
            in_valid = 1'b1;
            in_row   = nr;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 300 && done_cnt == start; i++) begin
            new_frame = ovr && (i == 0);
            stall     = stall_p && (i >= 1) && (i <= 5);
            @(posedge clk);
            #1;
        end
        new_frame = 1'b0;
        stall     = 1'b0;
        if (done_cnt == start) begin
            chk("frame_done_timeout", 0, 1);
        end else if (!SKIP || rows == 0) begin
            chk("frame_done_cycle", done_cyc,
                (words > 0) ? last_hs + 1 : nf + 2);
        end
        chk("row_progress", row_progress, m_prog);
        chk("count", count, q.size());
        chk("underflow", underflow, m_unf);
        chk("overrun", overrun, m_ovr);
        chk("words_left", exp_q.size(), 0);
    endtask

    task automatic abort_test();
        int pre, rows, words, start;
        push_row(rand_row());
        push_row(rand_row());
        model_frame(5, 1'b0, '0, pre, rows, words);
        start       = done_cnt;
        new_frame   = 1'b1;
        scroll_step = 8'd5;
        @(posedge clk);
        #1;
        new_frame = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midstream_reset");
        rst = 1'b0;
        q.delete();
        exp_q.delete();
        m_prog = 0;
        m_unf  = 1'b0;
        m_ovr  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("no_done_after_abort", done_cnt, start);
        chk("count_after_abort", count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_idle", in_ready, 1);

        push_row(rand_row());
        push_row({16'h0000, 16'h4A05, 16'h0000});
        push_row(rand_row());
        do_frame(10, 0, 0, 0);
        do_frame(50, 0, 0, 0);
        do_frame(10, 0, 0, 0);
        do_frame(200, 0, 0, 0);
        while (q.size() > 0) do_frame(64, 0, 0, 0);
        do_frame(64, 0, 0, 0);

        repeat (ROWS + 1) push_row(rand_row());
        do_frame(64, 1, 0, 0);
        do_frame(64, 1, 0, 0);

        pause = 1'b1;
        do_frame(30, 0, 0, 0);
        pause = 1'b0;
        do_frame(5, 0, 1, 1);

        repeat (20) begin
            repeat ($urandom_range(0, 3)) push_row(rand_row());
            pause = ($urandom_range(0, 5) == 0);
            do_frame($urandom_range(0, 90), 1'($urandom_range(0, 1)), 0, 0);
            pause = 1'b0;
        end

        abort_test();
        push_row(rand_row());
        push_row({16'h0000, 16'h4A05, 16'h0000});
        do_frame(20, 1, 0, 0);
        do_frame(70, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
